// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage.
// Consumes the EXE/MEM registers, drives a req/ack data-memory port with byte
// enables and lane-replicated store data, extracts and extends load data, and
// produces the MEM/WB registers. Upstream is stalled while an access is open.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned halfword and
// word accesses (adds the misalign_wb port); otherwise unusable low address
// bits are ignored.
module mem_stage #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_mem,
  input  logic [XLEN-1:0]           pc_mem,
  input  logic [XLEN-1:0]           alu_mem,
  input  logic [XLEN-1:0]           rs2_mem,
  input  logic [XLEN-1:0]           instr_mem,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_mem,
  output logic [XLEN-1:0]           forward_mem,
  output logic                      stall_mem,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [XLEN-1:0]           dmem_addr,
  output logic [XLEN-1:0]           dmem_wdata,
  output logic [3:0]                dmem_be,
  input  logic                      dmem_ack,
  input  logic [XLEN-1:0]           dmem_rdata,
  output logic                      valid_wb,
  output logic [XLEN-1:0]           pc_wb,
  output logic [XLEN-1:0]           instr_wb,
  output logic [XLEN-1:0]           wb_data,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_wb
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                      misalign_wb
`endif
);

  localparam int unsigned BE_W      = 4;
  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [2:0]  F3_B      = 3'b000;
  localparam logic [2:0]  F3_H      = 3'b001;
  localparam logic [2:0]  F3_BU     = 3'b100;
  localparam logic [2:0]  F3_HU     = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_e;

  // Byte enables for a store; unknown funct3 behaves as SW.
  function automatic logic [BE_W-1:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    store_be = 4'b0001 << off;
      F3_H:    store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane it could land in.
  function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] rs2);
    case (f3)
      F3_B:    store_data = {(XLEN/8){rs2[7:0]}};
      F3_H:    store_data = {(XLEN/16){rs2[15:0]}};
      default: store_data = rs2;
    endcase
  endfunction

  // Select the addressed byte/halfword and sign- or zero-extend it.
  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                   input logic [XLEN-1:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      F3_B:    load_extract = {{(XLEN-8){b[7]}}, b};
      F3_H:    load_extract = {{(XLEN-16){h[15]}}, h};
      F3_BU:   load_extract = {{(XLEN-8){1'b0}}, b};
      F3_HU:   load_extract = {{(XLEN-16){1'b0}}, h};
      default: load_extract = rdata;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  // Halfword needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic ld, input logic [2:0] f3, input logic [1:0] off);
    if (f3 == F3_B || (ld && f3 == F3_BU))
      is_misaligned = 1'b0;
    else if (f3 == F3_H || (ld && f3 == F3_HU))
      is_misaligned = off[0];
    else
      is_misaligned = (off != 2'b00);
  endfunction
`endif

  state_e state_q, state_d;

  // Access captured when the bus does not ack in the first request cycle
  logic [XLEN-1:0]           alu_q;
  logic [XLEN-1:0]           pc_q;
  logic [XLEN-1:0]           instr_q;
  logic [XLEN-1:0]           wdata_q;
  logic [BE_W-1:0]           be_q;
  logic                      we_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;

  // MEM/WB registers
  logic                      valid_wb_q, valid_wb_d;
  logic [XLEN-1:0]           pc_wb_q, pc_wb_d;
  logic [XLEN-1:0]           instr_wb_q, instr_wb_d;
  logic [XLEN-1:0]           wb_data_q, wb_data_d;
  logic [REG_ADDR_WIDTH-1:0] rd_wb_q, rd_wb_d;
  logic                      mis_wb_d;

  // Decode of the instruction currently in EXE/MEM
  logic                      is_load_in;
  logic                      is_store_in;
  logic                      mis_in;
  logic                      mem_op;
  logic [2:0]                f3_in;
  logic [XLEN-1:0]           addr_in;
  logic [XLEN-1:0]           wdata_in;
  logic [BE_W-1:0]           be_in;

  // Decode the incoming instruction and form its bus payload
  always_comb begin
    f3_in       = instr_mem[14:12];
    is_load_in  = (instr_mem[6:0] == OPC_LOAD);
    is_store_in = (instr_mem[6:0] == OPC_STORE);
`ifdef MEM_MISALIGN_TRAP_EN
    mis_in      = (is_load_in | is_store_in) & is_misaligned(is_load_in, f3_in, alu_mem[1:0]);
`else
    mis_in      = 1'b0;
`endif
    mem_op      = valid_mem & (is_load_in | is_store_in) & ~mis_in;
    addr_in     = {alu_mem[XLEN-1:2], 2'b00};
    wdata_in    = store_data(f3_in, rs2_mem);
    be_in       = is_store_in ? store_be(f3_in, alu_mem[1:0]) : 4'b1111;
  end

  assign forward_mem = alu_mem;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: park in BUS until the access is acked
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mem_op && !dmem_ack) state_d = S_BUS;
      S_BUS:   if (dmem_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: bus port from the inputs in IDLE, from the latched copy in BUS
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_be    = '0;
    stall_mem  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (mem_op) begin
            dmem_req   = 1'b1;
            dmem_we    = is_store_in;
            dmem_addr  = addr_in;
            dmem_wdata = wdata_in;
            dmem_be    = be_in;
          end
        end
        S_BUS: begin
          dmem_req   = 1'b1;
          dmem_we    = we_q;
          dmem_addr  = {alu_q[XLEN-1:2], 2'b00};
          dmem_wdata = wdata_q;
          dmem_be    = be_q;
        end
        default: ;
      endcase
      stall_mem = dmem_req & ~dmem_ack;
    end
  end

  // Capture the access when it has to wait for ack
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q   <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
    end else if (state_q == S_IDLE && mem_op && !dmem_ack) begin
      alu_q   <= alu_mem;
      pc_q    <= pc_mem;
      instr_q <= instr_mem;
      wdata_q <= wdata_in;
      be_q    <= be_in;
      we_q    <= is_store_in;
      rd_q    <= rd_addr_mem;
    end
  end

  // MEM/WB next value: bubble while stalled, else retire from BUS copy or inputs
  always_comb begin
    valid_wb_d = 1'b0;
    rd_wb_d    = '0;
    pc_wb_d    = pc_wb_q;
    instr_wb_d = instr_wb_q;
    wb_data_d  = wb_data_q;
    mis_wb_d   = 1'b0;
    if (stall_mem) begin
      valid_wb_d = 1'b0;
    end else if (state_q == S_BUS) begin
      valid_wb_d = 1'b1;
      rd_wb_d    = rd_q;
      pc_wb_d    = pc_q;
      instr_wb_d = instr_q;
      wb_data_d  = we_q ? alu_q : load_extract(instr_q[14:12], alu_q[1:0], dmem_rdata);
    end else begin
      valid_wb_d = valid_mem;
      rd_wb_d    = mis_in ? '0 : rd_addr_mem;
      pc_wb_d    = pc_mem;
      instr_wb_d = instr_mem;
      wb_data_d  = (mem_op && is_load_in) ? load_extract(f3_in, alu_mem[1:0], dmem_rdata) : alu_mem;
      mis_wb_d   = valid_mem & mis_in;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_wb_q <= 1'b0;
      rd_wb_q    <= '0;
      pc_wb_q    <= '0;
      instr_wb_q <= '0;
      wb_data_q  <= '0;
    end else begin
      valid_wb_q <= valid_wb_d;
      rd_wb_q    <= rd_wb_d;
      pc_wb_q    <= pc_wb_d;
      instr_wb_q <= instr_wb_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign valid_wb   = valid_wb_q;
  assign rd_addr_wb = rd_wb_q;
  assign pc_wb      = pc_wb_q;
  assign instr_wb   = instr_wb_q;
  assign wb_data    = wb_data_q;

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_wb_q;

  // Misalignment flag travels with the MEM/WB register
  always_ff @(posedge clk) begin
    if (rst) mis_wb_q <= 1'b0;
    else     mis_wb_q <= mis_wb_d;
  end

  assign misalign_wb = mis_wb_q;
`else
  logic unused_mis;
  assign unused_mis = mis_wb_d;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. Expected MEM/WB entries are
// queued when an instruction is driven and popped when valid_wb rises.
// Builds with or without MEM_MISALIGN_TRAP_EN.
module tb_mem_stage;

  typedef struct packed {
    logic        mis;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] data;
  } wb_t;

  localparam logic [31:0] ADDI_X5 = 32'h1230_0293;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_mem;
  logic [31:0] pc_mem, alu_mem, rs2_mem, instr_mem;
  logic [4:0]  rd_addr_mem;
  logic [31:0] forward_mem;
  logic        stall_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        valid_wb;
  logic [31:0] pc_wb, instr_wb, wb_data;
  logic [4:0]  rd_addr_wb;
  logic        mis_obs;

  int checks = 0;
  int errors = 0;
  wb_t sb[$];
  wb_t e, o;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .valid_mem(valid_mem),
    .pc_mem(pc_mem), .alu_mem(alu_mem), .rs2_mem(rs2_mem), .instr_mem(instr_mem),
    .rd_addr_mem(rd_addr_mem), .forward_mem(forward_mem), .stall_mem(stall_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .valid_wb(valid_wb), .pc_wb(pc_wb),
    .instr_wb(instr_wb), .wb_data(wb_data), .rd_addr_wb(rd_addr_wb)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_wb(mis_obs)
`endif
  );

`ifndef MEM_MISALIGN_TRAP_EN
  assign mis_obs = 1'b0;
`endif

  function automatic logic [31:0] enc_ld(input logic [2:0] f3);
    return {17'h0, f3, 5'd0, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_st(input logic [2:0] f3);
    return {17'h0, f3, 5'd0, 7'b0100011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd);
    valid_mem   = v;
    pc_mem      = pc;
    instr_mem   = instr;
    alu_mem     = alu;
    rs2_mem     = rs2;
    rd_addr_mem = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b1, 32'h10, enc_ld(3'b010), 32'h100, 32'h0, 5'd3);
    step();
    step();
    @(negedge clk);
    checks++;
    if ({valid_wb, rd_addr_wb, pc_wb, instr_wb, wb_data, mis_obs} !== '0) begin
      errors++;
      $display("FAIL reset_wb: v=%b rd=%0d pc=%h instr=%h data=%h mis=%b, want all 0",
               valid_wb, rd_addr_wb, pc_wb, instr_wb, wb_data, mis_obs);
    end
    checks++;
    if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus: req=%b stall=%b, want 0 0", dmem_req, stall_mem);
    end
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || valid_wb !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: req=%b valid_wb=%b, want 0 0", dmem_req, valid_wb);
    end
  endtask

  task automatic test_addi();
    step();
    drive(1'b1, 32'h100, ADDI_X5, 32'h0000_0123, 32'h0, 5'd5);
    sb.push_back('{mis: 1'b0, rd: 5'd5, pc: 32'h100, instr: ADDI_X5, data: 32'h123});
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || stall_mem !== 1'b0 || forward_mem !== 32'h123) begin
      errors++;
      $display("FAIL addi_issue: req=%b stall=%b fwd=%h, want 0 0 00000123", dmem_req, stall_mem, forward_mem);
    end
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b1;
    @(negedge clk);
    checks++;
    o = '{mis: mis_obs, rd: rd_addr_wb, pc: pc_wb, instr: instr_wb, data: wb_data};
    if (valid_wb !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL addi_retire: valid_wb=%b queued=%0d", valid_wb, sb.size());
    end else begin
      e = sb.pop_front();
      if (o !== e) begin errors++; $display("FAIL addi_retire: got %h want %h", o, e); end
    end
    checks++;
    if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack: req=%b stall=%b, want 0 0", dmem_req, stall_mem);
    end
    step();
    dmem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_wb !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack_wb: valid_wb=%b, want 0", valid_wb);
    end
  endtask

  task automatic test_sb_wait();
    int stall_cnt = 0;
    int vwb_cnt = 0;
    step();
    drive(1'b1, 32'h200, enc_st(3'b000), 32'h1003, 32'hAABB_CCDD, 5'd0);
    dmem_ack = 1'b0;
    sb.push_back('{mis: 1'b0, rd: 5'd0, pc: 32'h200, instr: enc_st(3'b000), data: 32'h1003});
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc > 0) begin
        step();
        alu_mem  = $urandom;
        rs2_mem  = $urandom;
        dmem_ack = (cyc == 3);
      end
      @(negedge clk);
      if (stall_mem === 1'b1) stall_cnt++;
      if (valid_wb === 1'b1) vwb_cnt++;
      checks++;
      if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !==
          {1'b1, 1'b1, 4'b1000, 32'h1000, 32'hDDDD_DDDD}) begin
        errors++;
        $display("FAIL sb_bus c%0d: req=%b we=%b be=%b addr=%h wdata=%h, want 1 1 1000 00001000 dddddddd",
                 cyc, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata);
      end
    end
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b0;
    @(negedge clk);
    if (valid_wb === 1'b1) vwb_cnt++;
    checks++;
    o = '{mis: mis_obs, rd: rd_addr_wb, pc: pc_wb, instr: instr_wb, data: wb_data};
    if (valid_wb !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL sb_retire: valid_wb=%b queued=%0d", valid_wb, sb.size());
    end else begin
      e = sb.pop_front();
      if (o !== e) begin errors++; $display("FAIL sb_retire: got %h want %h", o, e); end
    end
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL sb_req_drop: req=%b, want 0", dmem_req);
    end
    step();
    @(negedge clk);
    if (valid_wb === 1'b1) vwb_cnt++;
    checks++;
    if (stall_cnt != 3 || vwb_cnt != 1) begin
      errors++;
      $display("FAIL sb_counts: stall_cycles=%0d valid_wb_pulses=%0d, want 3 1", stall_cnt, vwb_cnt);
    end
  endtask

  task automatic test_loads();
    step();
    drive(1'b1, 32'h300, enc_ld(3'b000), 32'h2002, 32'h0, 5'd6);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0080_0000;
    sb.push_back('{mis: 1'b0, rd: 5'd6, pc: 32'h300, instr: enc_ld(3'b000), data: 32'hFFFF_FF80});
    @(negedge clk);
    checks++;
    if ({dmem_req, dmem_we, dmem_be, dmem_addr, stall_mem} !== {1'b1, 1'b0, 4'b1111, 32'h2000, 1'b0}) begin
      errors++;
      $display("FAIL lb_bus: req=%b we=%b be=%b addr=%h stall=%b, want 1 0 1111 00002000 0",
               dmem_req, dmem_we, dmem_be, dmem_addr, stall_mem);
    end
    step();
    drive(1'b1, 32'h304, enc_ld(3'b100), 32'h2002, 32'h0, 5'd7);
    sb.push_back('{mis: 1'b0, rd: 5'd7, pc: 32'h304, instr: enc_ld(3'b100), data: 32'h0000_0080});
    @(negedge clk);
    checks++;
    o = '{mis: mis_obs, rd: rd_addr_wb, pc: pc_wb, instr: instr_wb, data: wb_data};
    if (valid_wb !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL lb_retire: valid_wb=%b queued=%0d", valid_wb, sb.size());
    end else begin
      e = sb.pop_front();
      if (o !== e) begin errors++; $display("FAIL lb_retire: got %h want %h", o, e); end
    end
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b0;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    o = '{mis: mis_obs, rd: rd_addr_wb, pc: pc_wb, instr: instr_wb, data: wb_data};
    if (valid_wb !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL lbu_retire: valid_wb=%b queued=%0d", valid_wb, sb.size());
    end else begin
      e = sb.pop_front();
      if (o !== e) begin errors++; $display("FAIL lbu_retire: got %h want %h", o, e); end
    end
  endtask

  task automatic test_lh_sh();
    step();
    drive(1'b1, 32'h400, enc_ld(3'b001), 32'h3002, 32'h0, 5'd8);
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0BAD_F00D;
    sb.push_back('{mis: 1'b0, rd: 5'd8, pc: 32'h400, instr: enc_ld(3'b001), data: 32'hFFFF_8001});
    @(negedge clk);
    checks++;
    if (stall_mem !== 1'b1 || dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL lh_wait: stall=%b req=%b, want 1 1", stall_mem, dmem_req);
    end
    step();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h8001_1234;
    @(negedge clk);
    step();
    drive(1'b1, 32'h404, enc_st(3'b001), 32'h3002, 32'h0000_5678, 5'd0);
    dmem_rdata = 32'h0;
    sb.push_back('{mis: 1'b0, rd: 5'd0, pc: 32'h404, instr: enc_st(3'b001), data: 32'h3002});
    @(negedge clk);
    checks++;
    o = '{mis: mis_obs, rd: rd_addr_wb, pc: pc_wb, instr: instr_wb, data: wb_data};
    if (valid_wb !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL lh_retire: valid_wb=%b queued=%0d", valid_wb, sb.size());
    end else begin
      e = sb.pop_front();
      if (o !== e) begin errors++; $display("FAIL lh_retire: got %h want %h", o, e); end
    end
    checks++;
    if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !==
        {1'b1, 1'b1, 4'b1100, 32'h3000, 32'h5678_5678}) begin
      errors++;
      $display("FAIL sh_bus: req=%b we=%b be=%b addr=%h wdata=%h, want 1 1 1100 00003000 56785678",
               dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata);
    end
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b0;
    @(negedge clk);
    checks++;
    o = '{mis: mis_obs, rd: rd_addr_wb, pc: pc_wb, instr: instr_wb, data: wb_data};
    if (valid_wb !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL sh_retire: valid_wb=%b queued=%0d", valid_wb, sb.size());
    end else begin
      e = sb.pop_front();
      if (o !== e) begin errors++; $display("FAIL sh_retire: got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    // Per cycle: new, valid, instr, alu, rs2, rdata, ack, expected req, expected stall
    logic        t_new[7]   = '{1, 0, 1, 1, 1, 0, 0};
    logic        t_v[7]     = '{1, 1, 1, 1, 1, 0, 0};
    logic [31:0] t_instr[7] = '{enc_ld(3'b010), enc_ld(3'b010), enc_st(3'b010), enc_ld(3'b101),
                                32'h0770_0313, 32'h0, 32'h0};
    logic [31:0] t_alu[7]   = '{32'h5000, 32'h5000, 32'h5004, 32'h5006, 32'h77, 32'h0, 32'h0};
    logic [31:0] t_rdata[7] = '{32'h0, 32'hCAFE_BABE, 32'hDEAD_0000, 32'h9ABC_1234, 32'h1, 32'h0, 32'h0};
    logic        t_ack[7]   = '{0, 1, 1, 1, 0, 0, 0};
    logic        t_req[7]   = '{1, 1, 1, 1, 0, 0, 0};
    logic        t_stall[7] = '{1, 0, 0, 0, 0, 0, 0};
    logic [31:0] t_data[7]  = '{32'hCAFE_BABE, 32'h0, 32'h5004, 32'h0000_9ABC, 32'h77, 32'h0, 32'h0};
    int retires = 0;
    for (int c = 0; c < 7; c++) begin
      step();
      drive(t_v[c], 32'h500 + 32'(c), t_instr[c], t_alu[c], 32'h1122_3344, 5'(c + 10));
      dmem_ack   = t_ack[c];
      dmem_rdata = t_rdata[c];
      if (t_new[c])
        sb.push_back('{mis: 1'b0, rd: 5'(c + 10), pc: 32'h500 + 32'(c), instr: t_instr[c], data: t_data[c]});
      @(negedge clk);
      checks++;
      if (dmem_req !== t_req[c] || stall_mem !== t_stall[c]) begin
        errors++;
        $display("FAIL b2b_handshake c%0d: req=%b stall=%b, want %b %b", c, dmem_req, stall_mem, t_req[c], t_stall[c]);
      end
      if (valid_wb === 1'b1) begin
        retires++;
        checks++;
        o = '{mis: mis_obs, rd: rd_addr_wb, pc: pc_wb, instr: instr_wb, data: wb_data};
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_retire c%0d: unexpected retire %h", c, o);
        end else begin
          e = sb.pop_front();
          if (o !== e) begin errors++; $display("FAIL b2b_retire c%0d: got %h want %h", c, o, e); end
        end
      end
      if (c == 3) begin
        checks++;
        if (dmem_addr !== 32'h5004 || dmem_be !== 4'b1111 || dmem_we !== 1'b0) begin
          errors++;
          $display("FAIL lhu_bus: addr=%h be=%b we=%b, want 00005004 1111 0", dmem_addr, dmem_be, dmem_we);
        end
      end
    end
    checks++;
    if (retires != 4 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: retires=%0d left=%0d, want 4 0", retires, sb.size());
    end
  endtask

  task automatic test_reset_in_bus();
    step();
    drive(1'b1, 32'h600, enc_ld(3'b010), 32'h6000, 32'h0, 5'd12);
    dmem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_mem !== 1'b1 || dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rstbus_wait: stall=%b req=%b, want 1 1", stall_mem, dmem_req);
    end
    step();
    rst = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL rstbus_req_in_reset: req=%b, want 0", dmem_req);
    end
    step();
    rst = 1'b0;
    dmem_ack = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    checks++;
    if (valid_wb !== 1'b0 || rd_addr_wb !== 5'd0 || dmem_req !== 1'b0 || stall_mem !== 1'b0) begin
      errors++;
      $display("FAIL rstbus_after: valid_wb=%b rd=%0d req=%b stall=%b, want 0 0 0 0",
               valid_wb, rd_addr_wb, dmem_req, stall_mem);
    end
    step();
    drive(1'b1, 32'h610, 32'h0550_0393, 32'h55, 32'h0, 5'd7);
    sb.push_back('{mis: 1'b0, rd: 5'd7, pc: 32'h610, instr: 32'h0550_0393, data: 32'h55});
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin
      errors++;
      $display("FAIL rstbus_idle: req=%b stall=%b, want 0 0", dmem_req, stall_mem);
    end
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    checks++;
    o = '{mis: mis_obs, rd: rd_addr_wb, pc: pc_wb, instr: instr_wb, data: wb_data};
    if (valid_wb !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL rstbus_next_retire: valid_wb=%b queued=%0d", valid_wb, sb.size());
    end else begin
      e = sb.pop_front();
      if (o !== e) begin errors++; $display("FAIL rstbus_next_retire: got %h want %h", o, e); end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] ins[2] = '{enc_ld(3'b010), enc_st(3'b001)};
    logic [31:0] adr[2] = '{32'h4001, 32'h3003};
    logic [4:0]  rdv[2] = '{5'd9, 5'd0};
    for (int k = 0; k < 2; k++) begin
      step();
      drive(1'b1, 32'h700 + 32'(4 * k), ins[k], adr[k], 32'h0000_BEEF, rdv[k]);
      dmem_ack = 1'b1;
      dmem_rdata = 32'h1122_3344;
`ifdef MEM_MISALIGN_TRAP_EN
      sb.push_back('{mis: 1'b1, rd: 5'd0, pc: 32'h700 + 32'(4 * k), instr: ins[k], data: adr[k]});
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin
        errors++;
        $display("FAIL misalign_bus k%0d: req=%b stall=%b, want 0 0", k, dmem_req, stall_mem);
      end
`else
      sb.push_back('{mis: 1'b0, rd: rdv[k], pc: 32'h700 + 32'(4 * k), instr: ins[k],
                     data: (k == 0) ? 32'h1122_3344 : 32'h3003});
      @(negedge clk);
      checks++;
      if ({dmem_req, dmem_addr, dmem_be} !== {1'b1, (k == 0) ? 32'h4000 : 32'h3000, (k == 0) ? 4'b1111 : 4'b1100} ||
          (k == 1 && dmem_wdata !== 32'hBEEF_BEEF)) begin
        errors++;
        $display("FAIL misalign_bus k%0d: req=%b addr=%h be=%b wdata=%h", k, dmem_req, dmem_addr, dmem_be, dmem_wdata);
      end
`endif
      step();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
      dmem_ack = 1'b0;
      @(negedge clk);
      checks++;
      o = '{mis: mis_obs, rd: rd_addr_wb, pc: pc_wb, instr: instr_wb, data: wb_data};
      if (valid_wb !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL misalign_retire k%0d: valid_wb=%b queued=%0d", k, valid_wb, sb.size());
      end else begin
        e = sb.pop_front();
        if (o !== e) begin errors++; $display("FAIL misalign_retire k%0d: got %h want %h", k, o, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sb_wait();
    test_loads();
    test_lh_sh();
    test_back_to_back();
    test_reset_in_bus();
    test_misalign();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries never retired, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
